// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU control path: opcodes (common with the ALU),
// sequencer states, instruction field positions and flag bit indices.
package cpu_pkg;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_ADC = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_SBC = 5'h03;
  localparam logic [4:0] OP_AND = 5'h04;
  localparam logic [4:0] OP_OR  = 5'h05;
  localparam logic [4:0] OP_XOR = 5'h06;
  localparam logic [4:0] OP_NOT = 5'h07;
  localparam logic [4:0] OP_LSL = 5'h08;
  localparam logic [4:0] OP_LSR = 5'h09;
  localparam logic [4:0] OP_ASR = 5'h0A;
  localparam logic [4:0] OP_ROL = 5'h0B;
  localparam logic [4:0] OP_ROR = 5'h0C;
  localparam logic [4:0] OP_MOV = 5'h0D;
  localparam logic [4:0] OP_LD  = 5'h0E;
  localparam logic [4:0] OP_ST  = 5'h0F;
  localparam logic [4:0] OP_JMP = 5'h10;
  localparam logic [4:0] OP_JZ  = 5'h11;
  localparam logic [4:0] OP_JC  = 5'h12;
  localparam logic [4:0] OP_HLT = 5'h1F;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_TARGET,
    ST_HALT
  } state_e;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned RD_MSB  = 10;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS_MSB  = 6;
  localparam int unsigned RS_LSB  = 3;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic [4:0] ir_opcode(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cpu_sequencer_instr_decode.sv
// Combinational instruction classifier: splits the IR into its instruction
// class and register fields.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_alu,
  output logic        is_mov,
  output logic        is_ld,
  output logic        is_st,
  output logic        is_jmp,
  output logic        is_hlt,
  output logic        is_illegal,
  output logic [3:0]  rd,
  output logic [3:0]  rs
);

  logic [4:0] opc;
  logic       unused_rsvd;

  assign unused_rsvd = ^ir[2:0];

  always_comb begin
    opc        = ir_opcode(ir);
    rd         = ir[RD_MSB:RD_LSB];
    rs         = ir[RS_MSB:RS_LSB];
    is_alu     = (opc <= OP_ROR);
    is_mov     = (opc == OP_MOV);
    is_ld      = (opc == OP_LD);
    is_st      = (opc == OP_ST);
    // JZ and JC share the two-word jump sequence; the condition is applied later
    is_jmp     = (opc == OP_JMP) || (opc == OP_JZ) || (opc == OP_JC);
    is_hlt     = (opc == OP_HLT);
    is_illegal = !(is_alu || is_mov || is_ld || is_st || is_jmp || is_hlt);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control unit: fetches and decodes instructions, sequences
// register reads, ALU operations, loads/stores and jumps; owns PC, IR and flags.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  input  logic [15:0] alu_y,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic [3:0]  flags,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal_op
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic        run_q, run_d;

  logic        is_alu, is_mov, is_ld, is_st, is_jmp, is_hlt, is_illegal;
  logic [3:0]  rd, rs;
  logic [4:0]  opc;
  logic        take;

  instr_decode u_decode (
    .ir         (ir_q),
    .is_alu     (is_alu),
    .is_mov     (is_mov),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_jmp     (is_jmp),
    .is_hlt     (is_hlt),
    .is_illegal (is_illegal),
    .rd         (rd),
    .rs         (rs)
  );

  assign opc   = ir_opcode(ir_q);
  assign flags = flags_q;
  assign pc    = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flags_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flags_d    = flags_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    run_d      = 1'b1;
    take       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;

    unique case (state_q)
      // run_q keeps the first request off until one full cycle after reset release
      ST_FETCH: begin
        if (run_q) begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
          if (mem_ready) begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + 16'd1;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        rf_raddr_a = rd;
        rf_raddr_b = rs;
        opa_d      = rf_rdata_a;
        opb_d      = rf_rdata_b;
        if (is_alu || is_mov || is_ld || is_st) begin
          state_d = ST_EXEC;
        end else if (is_jmp) begin
          state_d = ST_TARGET;
        end else if (is_hlt) begin
          state_d = ST_HALT;
        end else begin
          illegal_op = is_illegal;
          state_d    = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_alu) begin
          alu_op          = opc;
          alu_a           = opa_q;
          alu_b           = opb_q;
          alu_cin         = flags_q[FLAG_C];
          rf_we           = 1'b1;
          rf_waddr        = rd;
          rf_wdata        = alu_y;
          flags_d[FLAG_Z] = alu_z;
          flags_d[FLAG_N] = alu_n;
          flags_d[FLAG_C] = alu_c;
          flags_d[FLAG_V] = alu_v;
          state_d         = ST_FETCH;
        end else if (is_mov) begin
          rf_we    = 1'b1;
          rf_waddr = rd;
          rf_wdata = opb_q;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        if (is_st) begin
          mem_we    = 1'b1;
          mem_addr  = opa_q;
          mem_wdata = opb_q;
        end else begin
          mem_addr = opb_q;
        end
        if (mem_ready) begin
          if (is_ld) begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = mem_rdata;
          end
          state_d = ST_FETCH;
        end
      end
      ST_TARGET: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          take = (opc == OP_JMP) ||
                 ((opc == OP_JZ) && flags_q[FLAG_Z]) ||
                 ((opc == OP_JC) && flags_q[FLAG_C]);
          pc_d    = take ? mem_rdata : (pc_q + 16'd1);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory, register file and ALU models
// around the sequencer, with cycle-accurate checks of a short program.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;

  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [4:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_cin, alu_z, alu_n, alu_c, alu_v;
  logic [3:0]  flags;
  logic [15:0] pc;
  logic        halted, illegal_op;

  logic        mem_req2, mem_we2;
  logic [15:0] mem_addr2, mem_wdata2;
  logic [3:0]  rf_raddr_a2, rf_raddr_b2, rf_waddr2;
  logic [15:0] rf_wdata2;
  logic        rf_we2;
  logic [4:0]  alu_op2;
  logic [15:0] alu_a2, alu_b2;
  logic        alu_cin2;
  logic [3:0]  flags2;
  logic [15:0] pc2;
  logic        halted2, illegal_op2;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:15];
  logic [3:0]  wcnt;
  logic        pl_mem, pl_rf;
  logic [15:0] pl_a, pl_d;
  logic [16:0] s;

  int unsigned tests;
  int unsigned fails;

  cpu_sequencer #(.RESET_PC(16'h0000), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .flags(flags), .pc(pc), .halted(halted), .illegal_op(illegal_op)
  );

  // Second instance only ever sees the undefined opcode 10111
  cpu_sequencer #(.RESET_PC(16'h0000), .HALT_ON_ILLEGAL(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst2_n),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(16'hB800), .mem_ready(1'b1),
    .rf_raddr_a(rf_raddr_a2), .rf_raddr_b(rf_raddr_b2),
    .rf_rdata_a(16'h0000), .rf_rdata_b(16'h0000),
    .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
    .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_cin(alu_cin2),
    .alu_y(16'h0000), .alu_z(1'b0), .alu_n(1'b0), .alu_c(1'b0), .alu_v(1'b0),
    .flags(flags2), .pc(pc2), .halted(halted2), .illegal_op(illegal_op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, 3 wait states at 0x0100, none elsewhere
  assign mem_rdata  = mem[mem_addr];
  assign mem_ready  = mem_req && (wcnt == ((mem_addr == 16'h0100) ? 4'd3 : 4'd0));
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (pl_mem) mem[pl_a] <= pl_d;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
    if (pl_rf) rf[pl_a[3:0]] <= pl_d;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (!mem_req || mem_ready) wcnt <= 4'd0;
    else wcnt <= wcnt + 4'd1;
  end

  // ALU reference for the operations the program uses
  always_comb begin
    s     = '0;
    alu_v = 1'b0;
    case (alu_op)
      5'd0: begin
        s     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
      end
      5'd1: begin
        s     = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
        alu_v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
      end
      5'd2: begin
        s     = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_v = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]);
      end
      5'd3: begin
        s     = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, alu_cin};
        alu_v = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]);
      end
      default: s = {1'b0, alu_a};
    endcase
    alu_y = s[15:0];
    alu_z = (s[15:0] == 16'h0000);
    alu_n = s[15];
    alu_c = s[16];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic poke_mem(input logic [15:0] a, input logic [15:0] d);
    pl_mem = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_mem = 1'b0;
  endtask

  task automatic poke_rf(input logic [3:0] a, input logic [15:0] d);
    pl_rf = 1'b1; pl_a = {12'd0, a}; pl_d = d;
    @(posedge clk); #1;
    pl_rf = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; rst2_n = 1'b0;
    pl_mem = 1'b0; pl_rf = 1'b0; pl_a = '0; pl_d = '0;

    // Program: enc = op<<11 | rd<<7 | rs<<3
    poke_mem(16'h0000, 16'h0090);  // ADD r1,r2
    poke_mem(16'h0001, 16'h1338);  // SUB r6,r7
    poke_mem(16'h0002, 16'h8800);  // JZ
    poke_mem(16'h0003, 16'h0040);
    poke_mem(16'h0040, 16'h0090);  // ADD r1,r2
    poke_mem(16'h0041, 16'h9000);  // JC (not taken)
    poke_mem(16'h0042, 16'h0300);
    poke_mem(16'h0043, 16'h71A0);  // LD r3,[r4]
    poke_mem(16'h0044, 16'h7A98);  // ST [r5],r3
    poke_mem(16'h0045, 16'h0448);  // ADD r8,r9
    poke_mem(16'h0046, 16'h0D58);  // ADC r10,r11
    poke_mem(16'h0047, 16'h6E18);  // MOV r12,r3
    poke_mem(16'h0048, 16'h13B8);  // SUB r7,r7
    poke_mem(16'h0049, 16'hB800);  // undefined 10111
    poke_mem(16'h004A, 16'h8000);  // JMP
    poke_mem(16'h004B, 16'hFFFF);
    poke_mem(16'hFFFF, 16'h76A0);  // LD r13,[r4]
    poke_mem(16'h0100, 16'hBEEF);
    poke_mem(16'h0200, 16'h0000);
    for (int unsigned r = 0; r < 16; r++) poke_rf(r[3:0], 16'h0000);
    poke_rf(4'd1, 16'd5);
    poke_rf(4'd2, 16'd7);
    poke_rf(4'd4, 16'h0100);
    poke_rf(4'd5, 16'h0200);
    poke_rf(4'd6, 16'h8000);
    poke_rf(4'd7, 16'h8000);
    poke_rf(4'd8, 16'hFFFF);
    poke_rf(4'd9, 16'h0001);

    step(1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'h0);
    check("rst_flags", {28'd0, flags}, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    rst_n = 1'b1;
    check("release_no_req", {31'd0, mem_req}, 32'd0);

    step(1);  // C1 fetch 0
    check("c1_req", {31'd0, mem_req}, 32'd1);
    check("c1_addr", {16'd0, mem_addr}, 32'h0);
    check("c1_we", {31'd0, mem_we}, 32'd0);
    step(1);  // C2 decode ADD
    check("c2_raddr_a", {28'd0, rf_raddr_a}, 32'd1);
    check("c2_raddr_b", {28'd0, rf_raddr_b}, 32'd2);
    check("c2_req", {31'd0, mem_req}, 32'd0);
    step(1);  // C3 exec ADD
    check("add_we", {31'd0, rf_we}, 32'd1);
    check("add_waddr", {28'd0, rf_waddr}, 32'd1);
    check("add_wdata", {16'd0, rf_wdata}, 32'd12);
    check("add_alu_a", {16'd0, alu_a}, 32'd5);
    check("add_alu_b", {16'd0, alu_b}, 32'd7);
    step(1);  // C4 fetch 1
    check("add_flags", {28'd0, flags}, 32'h0);
    check("c4_addr", {16'd0, mem_addr}, 32'h1);
    check("c4_rf_we_idle", {31'd0, rf_we}, 32'd0);
    check("c4_alu_a_idle", {16'd0, alu_a}, 32'd0);
    step(2);  // C6 exec SUB
    check("sub_op", {27'd0, alu_op}, 32'd2);
    check("sub_wdata", {16'd0, rf_wdata}, 32'd0);
    step(1);  // C7 fetch 2
    check("sub_flags", {28'd0, flags}, 32'hA);
    check("c7_addr", {16'd0, mem_addr}, 32'h2);
    step(2);  // C9 target fetch
    check("jz_target_req", {31'd0, mem_req}, 32'd1);
    check("jz_target_addr", {16'd0, mem_addr}, 32'h3);
    step(1);  // C10
    check("jz_taken_addr", {16'd0, mem_addr}, 32'h40);
    check("jz_taken_pc", {16'd0, pc}, 32'h40);
    step(2);  // C12
    check("add2_wdata", {16'd0, rf_wdata}, 32'd19);
    step(1);  // C13
    check("add2_flags", {28'd0, flags}, 32'h0);
    step(3);  // C16
    check("jc_not_taken_addr", {16'd0, mem_addr}, 32'h43);
    check("jc_not_taken_pc", {16'd0, pc}, 32'h43);
    step(3);  // C19..C22 load with wait states
    for (int unsigned w = 0; w < 4; w++) begin
      check("ld_req_held", {31'd0, mem_req}, 32'd1);
      check("ld_addr_held", {16'd0, mem_addr}, 32'h100);
      check("ld_we_held", {31'd0, mem_we}, 32'd0);
      check("ld_rf_we", {31'd0, rf_we}, (w == 3) ? 32'd1 : 32'd0);
      if (w < 3) step(1);
    end
    check("ld_waddr", {28'd0, rf_waddr}, 32'd3);
    check("ld_wdata", {16'd0, rf_wdata}, 32'hBEEF);
    step(1);  // C23
    check("ld_next_fetch", {16'd0, mem_addr}, 32'h44);
    check("ld_r3", {16'd0, rf[3]}, 32'hBEEF);
    step(3);  // C26 store
    check("st_we", {31'd0, mem_we}, 32'd1);
    check("st_addr", {16'd0, mem_addr}, 32'h200);
    check("st_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    step(1);  // C27
    check("st_mem", {16'd0, mem[16'h0200]}, 32'hBEEF);
    check("c27_addr", {16'd0, mem_addr}, 32'h45);
    step(3);  // C30
    check("add_carry_flags", {28'd0, flags}, 32'hA);
    step(2);  // C32 ADC
    check("adc_cin", {31'd0, alu_cin}, 32'd1);
    check("adc_op", {27'd0, alu_op}, 32'd1);
    check("adc_wdata", {16'd0, rf_wdata}, 32'd1);
    check("adc_waddr", {28'd0, rf_waddr}, 32'd10);
    step(1);  // C33
    check("adc_flags", {28'd0, flags}, 32'h0);
    step(2);  // C35 MOV
    check("mov_we", {31'd0, rf_we}, 32'd1);
    check("mov_waddr", {28'd0, rf_waddr}, 32'd12);
    check("mov_wdata", {16'd0, rf_wdata}, 32'hBEEF);
    check("mov_alu_b_idle", {16'd0, alu_b}, 32'd0);
    step(3);  // C38 SUB r7,r7
    check("subrr_a", {16'd0, alu_a}, 32'h8000);
    check("subrr_b", {16'd0, alu_b}, 32'h8000);
    check("subrr_wdata", {16'd0, rf_wdata}, 32'h0);
    step(1);  // C39
    check("subrr_flags", {28'd0, flags}, 32'hA);
    step(1);  // C40 decode undefined
    check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
    step(1);  // C41
    check("illegal_pulse_end", {31'd0, illegal_op}, 32'd0);
    check("illegal_continue", {16'd0, mem_addr}, 32'h4A);
    check("illegal_flags", {28'd0, flags}, 32'hA);
    step(3);  // C44
    check("fetch_ffff_addr", {16'd0, mem_addr}, 32'hFFFF);
    step(1);  // C45
    check("pc_wrap", {16'd0, pc}, 32'h0);
    step(2);  // C47 load in progress
    check("ld2_req", {31'd0, mem_req}, 32'd1);
    check("ld2_addr", {16'd0, mem_addr}, 32'h100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_pc", {16'd0, pc}, 32'h0);
    check("async_rst_flags", {28'd0, flags}, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("restart_req", {31'd0, mem_req}, 32'd1);
    check("restart_addr", {16'd0, mem_addr}, 32'h0);

    // HALT_ON_ILLEGAL=1 instance
    step(1);
    rst2_n = 1'b1;
    step(1);
    check("h_fetch_req", {31'd0, mem_req2}, 32'd1);
    step(1);
    check("h_illegal", {31'd0, illegal_op2}, 32'd1);
    step(1);
    check("h_illegal_end", {31'd0, illegal_op2}, 32'd0);
    for (int unsigned k = 0; k < 20; k++) begin
      check("h_halted", {31'd0, halted2}, 32'd1);
      check("h_no_req", {31'd0, mem_req2}, 32'd0);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
